// File: rtl/dk_ctrl_pkg.sv
// Shared types and constants for the Donkey Kong sprite motion sequencer.
package dk_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, WALK_R, WALK_L, THROW} dk_state_t;

  localparam logic [1:0] SPR_STAND = 2'b00;
  localparam logic [1:0] SPR_SIDE  = 2'b01;
  localparam logic [1:0] SPR_BLANK = 2'b10;

  localparam int SPRITE_W = 64;

endpackage

// File: rtl/dk_motion_ctrl_tick_counter.sv
// Modulo-MOD counter with enable and synchronous clear; wrap_o is a
// combinational pulse on the enabled count that rolls back to zero.
module tick_counter #(
  parameter int MOD = 8,
  parameter int W   = (MOD > 1) ? $clog2(MOD) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic wrap_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign wrap_o = en_i && (cnt_q == W'(MOD - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || wrap_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dk_motion_ctrl.sv
// Frame-rate sequencer for the DK sprite: patrols between two bounds, animates
// while walking and pauses to throw a barrel via a req/ack handshake.
module dk_motion_ctrl
  import dk_ctrl_pkg::*;
#(
  parameter logic [9:0] H_MIN        = 10'd160,
  parameter logic [9:0] H_MAX        = 10'd416,
  parameter logic [9:0] V_POS        = 10'd64,
  parameter logic [9:0] STEP         = 10'd2,
  parameter int         WALK_FRAMES  = 8,
  parameter int         THROW_PERIOD = 120,
  parameter int         THROW_HOLD   = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic       barrel_ack,
  output logic       barrel_req,
  output logic [9:0] curr_h,
  output logic [9:0] curr_v,
  output logic [1:0] sprite_selec,
  output logic       bounds_draw
);

  localparam int HW = $clog2(THROW_HOLD + 1);

  dk_state_t   state_q, state_d;
  logic        dir_q, dir_d;          // 1 = walking left
  logic [9:0]  h_q, h_d;
  logic [1:0]  spr_q, spr_d;
  logic        vis_q, vis_d;
  logic        req_q, req_d;
  logic        acked_q, acked_d;
  logic [HW-1:0] hold_q, hold_d;

  logic        adv, walk_tick, ack_now, acked, hold_done;
  logic        anim_wrap, throw_go, at_right, at_left;
  logic [10:0] h_inc;

  assign adv       = frame_tick && enable;
  assign walk_tick = adv && ((state_q == WALK_R) || (state_q == WALK_L));
  assign ack_now   = req_q && barrel_ack;
  assign acked     = acked_q || ack_now;
  assign hold_done = hold_q >= HW'(THROW_HOLD - 1);

  // 11-bit compares keep the bound checks free of wrap-around
  assign h_inc    = {1'b0, h_q} + {1'b0, STEP};
  assign at_right = h_inc >= {1'b0, H_MAX};
  assign at_left  = {1'b0, h_q} <= ({1'b0, H_MIN} + {1'b0, STEP});

  tick_counter #(.MOD(WALK_FRAMES)) u_anim_cnt (
    .clk    (clk),
    .rst    (rst),
    .en_i   (walk_tick),
    .clr_i  (throw_go),
    .wrap_o (anim_wrap)
  );

  tick_counter #(.MOD(THROW_PERIOD)) u_throw_cnt (
    .clk    (clk),
    .rst    (rst),
    .en_i   (walk_tick),
    .clr_i  (1'b0),
    .wrap_o (throw_go)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (adv) begin
      unique case (state_q)
        IDLE:    state_d = WALK_R;
        WALK_R:  state_d = throw_go ? THROW : (at_right ? WALK_L : WALK_R);
        WALK_L:  state_d = throw_go ? THROW : (at_left ? WALK_R : WALK_L);
        THROW:   if (hold_done && acked) state_d = dir_q ? WALK_L : WALK_R;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    h_d     = h_q;
    dir_d   = dir_q;
    spr_d   = spr_q;
    vis_d   = vis_q;
    req_d   = req_q;
    acked_d = acked_q;
    hold_d  = hold_q;
    if (ack_now) begin
      req_d   = 1'b0;
      acked_d = 1'b1;
    end
    if (adv) begin
      unique case (state_q)
        IDLE: vis_d = 1'b1;
        WALK_R: begin
          if (at_right) begin
            h_d   = H_MAX;
            dir_d = 1'b1;
          end else begin
            h_d = h_inc[9:0];
          end
        end
        WALK_L: begin
          if (at_left) begin
            h_d   = H_MIN;
            dir_d = 1'b0;
          end else begin
            h_d = h_q - STEP;
          end
        end
        THROW: if (hold_q < HW'(THROW_HOLD)) hold_d = hold_q + 1'b1;
        default: ;
      endcase
    end
    // Throw entry overrides the animation toggle of the same tick
    if (walk_tick) begin
      if (throw_go) begin
        spr_d   = SPR_STAND;
        req_d   = 1'b1;
        acked_d = 1'b0;
        hold_d  = '0;
      end else if (anim_wrap) begin
        spr_d = (spr_q == SPR_STAND) ? SPR_SIDE : SPR_STAND;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q     <= H_MIN;
      dir_q   <= 1'b0;
      spr_q   <= SPR_STAND;
      vis_q   <= 1'b0;
      req_q   <= 1'b0;
      acked_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      h_q     <= h_d;
      dir_q   <= dir_d;
      spr_q   <= spr_d;
      vis_q   <= vis_d;
      req_q   <= req_d;
      acked_q <= acked_d;
      hold_q  <= hold_d;
    end
  end

  assign barrel_req   = req_q;
  assign curr_h       = h_q;
  assign curr_v       = V_POS;
  assign sprite_selec = spr_q;
  assign bounds_draw  = vis_q;

endmodule

// File: tb/tb_dk_motion_ctrl.sv
// Randomized and directed checks of dk_motion_ctrl against a behavioural model.
module tb_dk_motion_ctrl;

  localparam int H_MIN        = 160;
  localparam int H_MAX        = 416;
  localparam int V_POS        = 64;
  localparam int STEP         = 2;
  localparam int WALK_FRAMES  = 8;
  localparam int THROW_PERIOD = 120;
  localparam int THROW_HOLD   = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       enable = 1'b0;
  logic       barrel_ack = 1'b0;
  logic       barrel_req;
  logic [9:0] curr_h;
  logic [9:0] curr_v;
  logic [1:0] sprite_selec;
  logic       bounds_draw;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: mode 0 idle, 1 walking, 2 throwing
  int m_mode, m_h, m_walks, m_hold;
  bit m_right, m_req, m_acked, m_vis;

  dk_motion_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .enable       (enable),
    .barrel_ack   (barrel_ack),
    .barrel_req   (barrel_req),
    .curr_h       (curr_h),
    .curr_v       (curr_v),
    .sprite_selec (sprite_selec),
    .bounds_draw  (bounds_draw)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_mode = 0; m_h = H_MIN; m_walks = 0; m_hold = 0;
    m_right = 1; m_req = 0; m_acked = 0; m_vis = 0;
  endtask

  task automatic model_clk(input bit t, input bit e, input bit a);
    if (m_req && a) begin
      m_req = 0;
      m_acked = 1;
    end
    if (t && e) begin
      if (m_mode == 0) begin
        m_mode = 1;
        m_vis = 1;
      end else if (m_mode == 1) begin
        if (m_right) begin
          if (m_h + STEP >= H_MAX) begin m_h = H_MAX; m_right = 0; end
          else m_h = m_h + STEP;
        end else begin
          if (m_h - STEP <= H_MIN) begin m_h = H_MIN; m_right = 1; end
          else m_h = m_h - STEP;
        end
        m_walks++;
        if (m_walks == THROW_PERIOD) begin
          m_mode = 2; m_walks = 0; m_hold = 0; m_req = 1; m_acked = 0;
        end
      end else begin
        m_hold++;
        if (m_hold >= THROW_HOLD && m_acked) m_mode = 1;
      end
    end
  endtask

  function automatic logic [23:0] mdl_vec();
    int spr;
    spr = (m_mode == 1) ? ((m_walks / WALK_FRAMES) % 2) : 0;
    return {m_req, m_vis, 2'(spr), 10'(V_POS), 10'(m_h)};
  endfunction

  function automatic logic [23:0] dut_vec();
    return {barrel_req, bounds_draw, sprite_selec, curr_v, curr_h};
  endfunction

  task automatic clk_step(input bit t, input bit e, input bit a);
    frame_tick = t; enable = e; barrel_ack = a;
    @(posedge clk);
    model_clk(t, e, a);
    #1;
    frame_tick = 1'b0; barrel_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    n_tests++; if (curr_h !== 10'd160) begin n_fail++; $display("FAIL reset_h got %0d want 160", curr_h); end
    n_tests++; if (curr_v !== 10'd64) begin n_fail++; $display("FAIL reset_v got %0d want 64", curr_v); end
    n_tests++; if (sprite_selec !== 2'b00) begin n_fail++; $display("FAIL reset_spr got %b want 00", sprite_selec); end
    n_tests++; if (bounds_draw !== 1'b0) begin n_fail++; $display("FAIL reset_vis got %b want 0", bounds_draw); end
    n_tests++; if (barrel_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", barrel_req); end
    rst = 1'b0;
    clk_step(0, 1, 0);
    clk_step(1, 1, 0);
    n_tests++; if (bounds_draw !== 1'b1 || curr_h !== 10'd160) begin
      n_fail++; $display("FAIL first_tick vis=%b h=%0d want vis=1 h=160", bounds_draw, curr_h);
    end
  endtask

  task automatic test_animation();
    logic [23:0] snap;
    for (int i = 1; i <= 16; i++) begin
      clk_step(1, 1, 0);
      if (i == 7) begin
        snap = mdl_vec();
        for (int j = 0; j < 3; j++) clk_step(1, 0, 0);
        n_tests++; if (dut_vec() !== snap) begin
          n_fail++; $display("FAIL frozen_by_enable got %h want %h", dut_vec(), snap);
        end
      end
      if (i == 8) begin
        n_tests++; if (sprite_selec !== 2'b01) begin n_fail++; $display("FAIL anim_tick8 got %b want 01", sprite_selec); end
      end
    end
    n_tests++; if (sprite_selec !== 2'b00 || curr_h !== 10'd192) begin
      n_fail++; $display("FAIL anim_tick16 spr=%b h=%0d want 00 192", sprite_selec, curr_h);
    end
  endtask

  task automatic test_throw();
    for (int i = 17; i <= 120; i++) clk_step(1, 1, 0);
    n_tests++; if (barrel_req !== 1'b1 || sprite_selec !== 2'b00 || curr_h !== 10'd400) begin
      n_fail++; $display("FAIL throw_entry req=%b spr=%b h=%0d want 1 00 400", barrel_req, sprite_selec, curr_h);
    end
    repeat (4) clk_step(0, 1, 0);
    n_tests++; if (barrel_req !== 1'b1) begin n_fail++; $display("FAIL req_held got %b want 1", barrel_req); end
    clk_step(0, 1, 1);
    n_tests++; if (barrel_req !== 1'b0) begin n_fail++; $display("FAIL req_after_ack got %b want 0", barrel_req); end
    for (int k = 1; k <= 30; k++) clk_step(1, 1, 0);
    n_tests++; if (curr_h !== 10'd400 || dut_vec() !== mdl_vec()) begin
      n_fail++; $display("FAIL throw_hold h=%0d want 400", curr_h);
    end
    clk_step(1, 1, 0);
    n_tests++; if (curr_h !== 10'd402) begin n_fail++; $display("FAIL resume_h got %0d want 402", curr_h); end
  endtask

  task automatic test_patrol_bound();
    for (int i = 0; i < 7; i++) clk_step(1, 1, 0);
    n_tests++; if (curr_h !== 10'd416) begin n_fail++; $display("FAIL right_bound got %0d want 416", curr_h); end
    clk_step(1, 1, 0);
    n_tests++; if (curr_h !== 10'd414) begin n_fail++; $display("FAIL turn_left got %0d want 414", curr_h); end
  endtask

  task automatic test_late_ack();
    int budget;
    int h0;
    budget = 300;
    while (!m_req && budget > 0) begin
      clk_step(1, 1, 0);
      n_tests++; if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL walk_to_throw got %h want %h", dut_vec(), mdl_vec());
      end
      budget--;
    end
    n_tests++; if (budget == 0) begin n_fail++; $display("FAIL throw_timeout got none want req"); end
    h0 = m_h;
    for (int i = 0; i < 40; i++) clk_step(1, 1, 0);
    n_tests++; if (barrel_req !== 1'b1 || curr_h !== 10'(h0)) begin
      n_fail++; $display("FAIL late_hold req=%b h=%0d want 1 %0d", barrel_req, curr_h, h0);
    end
    clk_step(0, 1, 1);
    clk_step(1, 1, 0);
    n_tests++; if (barrel_req !== 1'b0 || curr_h !== 10'(h0)) begin
      n_fail++; $display("FAIL late_exit req=%b h=%0d want 0 %0d", barrel_req, curr_h, h0);
    end
    clk_step(1, 1, 0);
    n_tests++; if (curr_h !== 10'(m_h) || m_h == h0) begin
      n_fail++; $display("FAIL late_resume h=%0d want %0d", curr_h, m_h);
    end
  endtask

  task automatic test_random();
    bit t, e, a;
    for (int i = 0; i < 3000; i++) begin
      t = ($urandom_range(0, 1) == 1);
      e = ($urandom_range(0, 4) != 0);
      a = ($urandom_range(0, 5) == 0);
      clk_step(t, e, a);
      n_tests++; if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL random_%0d got %h want %h", i, dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    int budget;
    budget = 600;
    while (!(m_req && barrel_req) && budget > 0) begin
      clk_step(1, 1, 0);
      budget--;
    end
    n_tests++; if (barrel_req !== 1'b1) begin n_fail++; $display("FAIL pre_reset_req got %b want 1", barrel_req); end
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    n_tests++; if (barrel_req !== 1'b0 || curr_h !== 10'd160 || sprite_selec !== 2'b00 ||
                   bounds_draw !== 1'b0 || curr_v !== 10'd64) begin
      n_fail++; $display("FAIL async_reset req=%b h=%0d spr=%b vis=%b want 0 160 00 0", barrel_req, curr_h, sprite_selec, bounds_draw);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    clk_step(1, 1, 0);
    clk_step(1, 1, 0);
    n_tests++; if (dut_vec() !== mdl_vec() || curr_h !== 10'd162) begin
      n_fail++; $display("FAIL post_reset got %h want %h", dut_vec(), mdl_vec());
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_animation();
    test_throw();
    test_patrol_bound();
    test_late_ack();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
